udma_l2_responder: RTL and testbench

- Synthesizable multi-port L2/TCDM memory responder. It serves as the slave end of the uDMA L2 read-only and write-only request channels (req/gnt/add/wen/be/wdata in, rvalid/rdata out).
- It replaces behavioural memory models in FPGA/emulation builds of the uDMA subsystem.
- A single flop- or SRAM-backed word array is shared by all ports through a round-robin arbiter.
- A programmable LFSR-driven stall injector withholds grants, to stress uDMA channel back-pressure.

---
 rtl/udma_l2_responder.sv | 114 +++++++++++
 tb/tb_udma_l2_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_l2_responder.sv
// Multi-port L2/TCDM memory responder for uDMA emulation builds: a shared word array behind a
// round-robin arbiter, with an LFSR-driven grant stall injector for back-pressure stress.
module udma_l2_responder #(
  parameter int unsigned NB_PORTS  = 2,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1C000000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_resetn_i,
  input  logic                      stall_en_i,
  input  logic [15:0]               stall_thresh_i,
  input  logic [NB_PORTS-1:0]       tcdm_req_i,
  output logic [NB_PORTS-1:0]       tcdm_gnt_o,
  input  logic [NB_PORTS-1:0][31:0] tcdm_add_i,
  input  logic [NB_PORTS-1:0]       tcdm_wen_i,
  input  logic [NB_PORTS-1:0][3:0]  tcdm_be_i,
  input  logic [NB_PORTS-1:0][31:0] tcdm_data_i,
  output logic [NB_PORTS-1:0]       tcdm_r_valid_o,
  output logic [NB_PORTS-1:0][31:0] tcdm_r_data_o,
  output logic [15:0]               err_cnt_o
);

  localparam int unsigned PtrW     = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int unsigned AddrW    = $clog2(MEM_WORDS);
  localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 4);
  localparam logic [31:0] OorData  = 32'hBADACCE5;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  logic [15:0]               lfsr_q, lfsr_d;
  logic                      stall;
  logic [PtrW-1:0]           rr_q, rr_d;
  logic [PtrW-1:0]           win_idx;
  logic                      win_vld;
  logic [31:0]               win_add, win_data, offset;
  logic [3:0]                win_be;
  logic                      win_wen, in_range;
  logic [AddrW-1:0]          word_idx;
  logic [31:0]               mem_q [MEM_WORDS];
  logic [NB_PORTS-1:0]       rvalid_q;
  logic [NB_PORTS-1:0][31:0] rdata_q;
  logic [15:0]               err_q, err_d;

  // Galois form, x^16+x^14+x^13+x^11; free-running so stall timing is traffic independent.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
    stall  = stall_en_i && (lfsr_q < stall_thresh_i);
  end

  // Grant uses only req, pointer and stall, so no path exists from the response side.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (!stall) begin
      for (int k = 0; k < int'(NB_PORTS); k++) begin
        if (!win_vld && tcdm_req_i[(int'(rr_q) + k) % int'(NB_PORTS)]) begin
          win_vld = 1'b1;
          win_idx = PtrW'((int'(rr_q) + k) % int'(NB_PORTS));
        end
      end
    end
    tcdm_gnt_o = '0;
    if (win_vld) tcdm_gnt_o[win_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (win_vld) rr_d = (int'(win_idx) == int'(NB_PORTS) - 1) ? '0 : win_idx + PtrW'(1);
  end

  always_comb begin
    win_add  = tcdm_add_i[win_idx];
    win_data = tcdm_data_i[win_idx];
    win_be   = tcdm_be_i[win_idx];
    win_wen  = tcdm_wen_i[win_idx];
    offset   = win_add - BASE_ADDR;
    in_range = offset < MemBytes;
    word_idx = offset[AddrW+1:2];
    err_d    = err_q;
    if (win_vld && !in_range && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  // Storage is deliberately unreset so it can map onto block RAM.
  always_ff @(posedge sys_clk_i) begin
    if (win_vld && in_range && !win_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (win_be[b]) mem_q[word_idx][8*b +: 8] <= win_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      lfsr_q   <= LFSR_SEED;
      rr_q     <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      rr_q     <= rr_d;
      rvalid_q <= tcdm_gnt_o;
      err_q    <= err_d;
      for (int p = 0; p < int'(NB_PORTS); p++) begin
        if (tcdm_gnt_o[p] && tcdm_wen_i[p]) rdata_q[p] <= in_range ? mem_q[word_idx] : OorData;
      end
    end
  end

  assign tcdm_r_valid_o = rvalid_q;
  assign tcdm_r_data_o  = rdata_q;
  assign err_cnt_o      = err_q;

endmodule

// File: tb/tb_udma_l2_responder.sv
// Directed bench for udma_l2_responder: a transaction-level memory/arbiter model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_udma_l2_responder;

  localparam int unsigned NP   = 2;
  localparam int unsigned MW   = 1024;
  localparam logic [31:0] BASE = 32'h1C000000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                clk, rst_n, stall_en;
  logic [15:0]         thresh, err_cnt;
  logic [NP-1:0]       req, gnt, wen, rvalid;
  logic [NP-1:0][31:0] add, wdata, rdata;
  logic [NP-1:0][3:0]  be;

  int errors = 0;
  int checks = 0;

  udma_l2_responder #(
    .NB_PORTS (NP),
    .MEM_WORDS(MW),
    .BASE_ADDR(BASE),
    .LFSR_SEED(SEED)
  ) dut (
    .sys_clk_i     (clk),
    .sys_resetn_i  (rst_n),
    .stall_en_i    (stall_en),
    .stall_thresh_i(thresh),
    .tcdm_req_i    (req),
    .tcdm_gnt_o    (gnt),
    .tcdm_add_i    (add),
    .tcdm_wen_i    (wen),
    .tcdm_be_i     (be),
    .tcdm_data_i   (wdata),
    .tcdm_r_valid_o(rvalid),
    .tcdm_r_data_o (rdata),
    .err_cnt_o     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Model state: what the memory system must look like after each clock edge.
  logic [31:0]   m_mem [MW];
  bit            m_known [MW];
  logic [15:0]   m_lfsr = SEED;
  int            m_rr = 0;
  logic [NP-1:0] m_rv = '0;
  logic [31:0]   m_rd [NP];
  bit            m_rdk [NP];
  logic [15:0]   m_err = '0;
  logic [NP-1:0] exp_g;
  int            win, idx;
  logic [31:0]   off;
  bit            cnt_en = 1'b0;
  int            cnt_g [NP];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_lfsr = SEED;
      m_rr   = 0;
      m_rv   = '0;
      m_err  = '0;
      for (int p = 0; p < int'(NP); p++) begin
        m_rd[p]  = '0;
        m_rdk[p] = 1'b1;
      end
    end
    for (int p = 0; p < int'(NP); p++) begin
      chk($sformatf("r_valid[%0d]", p), 32'(rvalid[p]), 32'(m_rv[p]));
      if (m_rdk[p]) chk($sformatf("r_data[%0d]", p), rdata[p], m_rd[p]);
    end
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    exp_g = '0;
    win   = -1;
    if (rst_n && !(stall_en && m_lfsr < thresh)) begin
      for (int k = 0; k < int'(NP); k++) begin
        if (win < 0 && req[(m_rr + k) % int'(NP)]) win = (m_rr + k) % int'(NP);
      end
    end
    if (win >= 0) exp_g[win] = 1'b1;
    chk("gnt", 32'(gnt), 32'(exp_g));
    if (cnt_en) for (int p = 0; p < int'(NP); p++) cnt_g[p] += int'(gnt[p]);
    if (rst_n) begin
      m_rv = exp_g;
      if (win >= 0) begin
        off = add[win] - BASE;
        if (off < MW * 4) begin
          idx = int'(off >> 2);
          if (wen[win]) begin
            m_rd[win]  = m_mem[idx];
            m_rdk[win] = m_known[idx];
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (be[win][b]) m_mem[idx][8*b +: 8] = wdata[win][8*b +: 8];
            end
            if (be[win] == 4'hF) m_known[idx] = 1'b1;
          end
        end else begin
          if (wen[win]) begin
            m_rd[win]  = 32'hBADACCE5;
            m_rdk[win] = 1'b1;
          end
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        m_rr = (win + 1) % int'(NP);
      end
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Holds the request until granted; returns at 1 ns after the grant edge (or -1 on timeout).
  task automatic access(input int p, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int waited);
    req[p]   = 1'b1;
    add[p]   = a;
    wen[p]   = w;
    be[p]    = b;
    wdata[p] = d;
    waited   = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (gnt[p]) begin
        waited = n;
        break;
      end
    end
    if (waited < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout[%0d]: got no grant, required one within 64 cycles", p);
    end else begin
      @(posedge clk);
    end
    #1 req[p] = 1'b0;
  endtask

  int           wt, ngrant;
  logic [6:0]   pat;
  logic [31:0]  exp_w;

  initial begin
    rst_n = 1'b1; stall_en = 1'b0; thresh = '0;
    req = '0; add = '0; wen = '1; be = '0; wdata = '0;
    for (int p = 0; p < int'(NP); p++) cnt_g[p] = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_r_valid", 32'(rvalid), 32'd0);

    // Write then read the same word on consecutive cycles; threshold 0 never stalls.
    stall_en = 1'b1; thresh = 16'h0000;
    access(1, 32'h1C000010, 1'b0, 4'hF, 32'hDEADBEEF, wt);
    chk("wr_gnt_latency", 32'(wt), 32'd0);
    chk("wr_r_valid", 32'(rvalid[1]), 32'd1);
    access(0, 32'h1C000010, 1'b1, 4'h0, 32'h0, wt);
    chk("rd_gnt_latency", 32'(wt), 32'd0);
    chk("rd_r_valid", 32'(rvalid[0]), 32'd1);
    chk("rd_after_wr", rdata[0], 32'hDEADBEEF);

    // Byte-enable merge.
    stall_en = 1'b0;
    access(1, 32'h1C000000, 1'b0, 4'hF, 32'h11223344, wt);
    access(1, 32'h1C000000, 1'b0, 4'b0101, 32'hAABBCCDD, wt);
    access(0, 32'h1C000003, 1'b1, 4'h0, 32'h0, wt);
    chk("be_merge", rdata[0], 32'h11BB33DD);
    for (int i = 1; i < 7; i++) access(1, BASE + 32'(4 * i), 1'b0, 4'hF, 32'hC0DE0000 + 32'(i), wt);

    // Both ports requesting continuously must alternate.
    req = '1; wen = '1; add[0] = 32'h1C000004; add[1] = 32'h1C000008; cnt_en = 1'b1;
    repeat (8) @(posedge clk);
    #1 req = '0; cnt_en = 1'b0;
    chk("rr_grants_p0", 32'(cnt_g[0]), 32'd4);
    chk("rr_grants_p1", 32'(cnt_g[1]), 32'd4);

    // Near-total stall at threshold FFFF.
    stall_en = 1'b1; thresh = 16'hFFFF; req[0] = 1'b1; add[0] = BASE;
    repeat (4) @(posedge clk);
    #1 req[0] = 1'b0;

    // Stalled read burst; data must follow the preload in order.
    thresh = 16'h8000; ngrant = 0;
    for (int i = 0; i < 7; i++) begin
      access(0, BASE + 32'(4 * i), 1'b1, 4'h0, 32'h0, wt);
      if (wt >= 0) ngrant++;
      exp_w = (i == 0) ? 32'h11BB33DD : 32'hC0DE0000 + 32'(i);
      chk($sformatf("burst_data[%0d]", i), rdata[0], exp_w);
    end
    chk("burst_grants", 32'(ngrant), 32'd7);

    // Out-of-range read and write.
    stall_en = 1'b0;
    access(0, 32'h1C001000, 1'b1, 4'h0, 32'h0, wt);
    chk("oor_read", rdata[0], 32'hBADACCE5);
    access(1, 32'h1B000000, 1'b0, 4'hF, 32'hFFFFFFFF, wt);
    access(0, 32'h1C000000, 1'b1, 4'h0, 32'h0, wt);
    chk("oor_write_dropped", rdata[0], 32'h11BB33DD);
    chk("oor_err_cnt", 32'(err_cnt), 32'd2);

    // Reset right after a read grant kills the response.
    access(0, 32'h1C000004, 1'b1, 4'h0, 32'h0, wt);
    rst_n = 1'b0;
    #1;
    chk("rst_r_valid", 32'(rvalid[0]), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    stall_en = 1'b1; thresh = 16'h8000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; req[0] = 1'b1; add[0] = BASE; wen[0] = 1'b1;
    // From seed ACE1: E270, 7138, 389C, 1C4E, 0E27, B313 -> grants on cycles 0, 1, 6.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat[i] = gnt[0];
    end
    @(posedge clk);
    #1 req[0] = 1'b0;
    chk("lfsr_reload_pattern", 32'(pat), 32'(7'b1000011));
    chk("mem_retained_valid", 32'(rvalid[0]), 32'd1);
    chk("mem_retained", rdata[0], 32'h11BB33DD);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
